// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style character-LCD bus controller.
// Holds the FSM state encoding, the power-up init ROM and the command/status field map.
package lcd_pkg;

    typedef enum logic [2:0] {
        POWERUP,
        INIT,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        EXEC
    } lcd_state_e;

    // Power-up init sequence: 8-bit/2-line function set x3, display on, clear, entry mode.
    localparam int INIT_LEN = 6;
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38, 8'h38, 8'h38};

    localparam int STAT_BUSY      = 0;
    localparam int STAT_PEND      = 1;
    localparam int STAT_OVF       = 2;
    localparam int STAT_INIT_DONE = 3;
    localparam int STAT_ON        = 31;

    localparam int CW_ON       = 31;
    localparam int CW_RS       = 9;
    localparam int CW_DATA_LSB = 0;
    localparam int CW_DATA_W   = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data[7:1] == 7'b0000000) || (data[7:1] == 7'b0000001));
    endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Load-and-count-down delay timer shared by every timed controller state.
// A load of N-1 makes o_done rise N cycles after the load, so a value of 0 gives a one-cycle state.
module lcd_delay_timer #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_count <= RESET_VALUE;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Character-LCD bus controller: power-up init, then one timed bus cycle per LSU command word,
// with a one-entry pending buffer, sticky overflow flag and a pollable status word.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int T_POWERUP   = 750000,
    parameter int T_SETUP     = 3,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_cmd_valid,
    input  logic [31:0] i_cmd_word,
    input  logic        i_clr_ovf,
    output logic        o_busy,
    output logic [31:0] o_status,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);

    localparam int T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_PULSE, T_HOLD)),
                                max2(T_EXEC, T_EXEC_LONG));
    localparam int W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

    localparam logic [W-1:0] LD_POWERUP   = W'(T_POWERUP - 1);
    localparam logic [W-1:0] LD_SETUP     = W'(T_SETUP - 1);
    localparam logic [W-1:0] LD_PULSE     = W'(T_PULSE - 1);
    localparam logic [W-1:0] LD_HOLD      = W'(T_HOLD - 1);
    localparam logic [W-1:0] LD_EXEC      = W'(T_EXEC - 1);
    localparam logic [W-1:0] LD_EXEC_LONG = W'(T_EXEC_LONG - 1);

    lcd_state_e       r_state;
    logic [2:0]       r_init_idx;
    logic             r_rs;
    logic [7:0]       r_data;
    logic             r_pend_vld;
    logic             r_pend_rs;
    logic [7:0]       r_pend_data;
    logic             r_ovf;
    logic             r_init_done;
    logic             r_on;
    logic             r_en;
    logic             r_busy;

    logic             w_done;
    logic             w_load;
    logic [W-1:0]     w_value;
    logic             w_init_more;
    logic             w_exec_exit;
    logic             w_take_pend;
    logic             w_direct;
    logic             w_to_pend;
    logic             w_drop;
    logic             w_cmd_rs;
    logic [7:0]       w_cmd_data;
    logic [31:0]      w_status;
    logic             w_unused_bits;

    assign w_cmd_rs      = i_cmd_word[CW_RS];
    assign w_cmd_data    = i_cmd_word[CW_DATA_LSB +: CW_DATA_W];
    assign w_unused_bits = ^{i_cmd_word[30:10], i_cmd_word[8]};

    assign w_init_more = (r_init_idx < 3'(INIT_LEN));
    assign w_exec_exit = (r_state == EXEC) && w_done;
    assign w_take_pend = w_exec_exit && !w_init_more && r_pend_vld;
    // A word arriving as the last EXEC ends with nothing pending starts directly, like from IDLE.
    assign w_direct    = i_cmd_valid &&
                         ((r_state == IDLE) || (w_exec_exit && !w_init_more && !r_pend_vld));
    assign w_to_pend   = i_cmd_valid && !w_direct && (!r_pend_vld || w_take_pend);
    assign w_drop      = i_cmd_valid && !w_direct && !w_to_pend;

    lcd_delay_timer #(
        .WIDTH       (W),
        .RESET_VALUE (LD_POWERUP)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (w_load),
        .i_value   (w_value),
        .o_done    (w_done)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_load  = 1'b0;
        w_value = '0;
        case (r_state)
            INIT: begin
                w_load  = 1'b1;
                w_value = LD_SETUP;
            end
            IDLE: begin
                w_load  = i_cmd_valid;
                w_value = LD_SETUP;
            end
            SETUP: begin
                w_load  = w_done;
                w_value = LD_PULSE;
            end
            PULSE: begin
                w_load  = w_done;
                w_value = LD_HOLD;
            end
            HOLD: begin
                w_load  = w_done;
                w_value = is_long_cmd(r_rs, r_data) ? LD_EXEC_LONG : LD_EXEC;
            end
            EXEC: begin
                w_load  = w_take_pend || w_direct;
                w_value = LD_SETUP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= POWERUP;
            r_init_idx  <= '0;
            r_rs        <= 1'b0;
            r_data      <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_rs   <= 1'b0;
            r_pend_data <= '0;
            r_ovf       <= 1'b0;
            r_init_done <= 1'b0;
            r_on        <= 1'b0;
            r_en        <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_busy <= 1'b1;
            r_en   <= 1'b0;
            case (r_state)
                POWERUP: if (w_done) r_state <= INIT;
                INIT: begin
                    r_rs       <= 1'b0;
                    r_data     <= INIT_ROM[r_init_idx];
                    r_init_idx <= r_init_idx + 3'd1;
                    r_state    <= SETUP;
                end
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_rs    <= w_cmd_rs;
                        r_data  <= w_cmd_data;
                        r_state <= SETUP;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                SETUP: begin
                    if (w_done) begin
                        r_state <= PULSE;
                        r_en    <= 1'b1;
                    end
                end
                PULSE: begin
                    if (w_done) r_state <= HOLD;
                    else        r_en    <= 1'b1;
                end
                HOLD: if (w_done) r_state <= EXEC;
                EXEC: begin
                    if (w_done) begin
                        if (w_init_more) begin
                            r_state <= INIT;
                        end else begin
                            r_init_done <= 1'b1;
                            if (r_pend_vld) begin
                                r_rs    <= r_pend_rs;
                                r_data  <= r_pend_data;
                                r_state <= SETUP;
                            end else if (i_cmd_valid) begin
                                r_rs    <= w_cmd_rs;
                                r_data  <= w_cmd_data;
                                r_state <= SETUP;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end
                default: r_state <= POWERUP;
            endcase

            if (w_to_pend) begin
                r_pend_vld  <= 1'b1;
                r_pend_rs   <= w_cmd_rs;
                r_pend_data <= w_cmd_data;
            end else if (w_take_pend) begin
                r_pend_vld  <= 1'b0;
            end

            if (w_drop)         r_ovf <= 1'b1;
            else if (i_clr_ovf) r_ovf <= 1'b0;

            if (i_cmd_valid && !w_drop) r_on <= i_cmd_word[CW_ON];
        end
    end

    always_comb begin
        w_status                 = '0;
        w_status[STAT_BUSY]      = r_busy;
        w_status[STAT_PEND]      = r_pend_vld;
        w_status[STAT_OVF]       = r_ovf;
        w_status[STAT_INIT_DONE] = r_init_done;
        w_status[STAT_ON]        = r_on;
    end

    assign o_status   = w_status;
    assign o_busy     = r_busy;
    assign o_lcd_on   = r_on;
    assign o_lcd_en   = r_en;
    assign o_lcd_rs   = r_rs;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_data = r_data;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: a transaction-level model predicts every EN pulse
// (RS, data, rise cycle, width) and the status word; directed cases plus a random run.
module tb_lcd_ctrl;

    localparam int TPU = 20;
    localparam int TS  = 2;
    localparam int TP  = 4;
    localparam int TH  = 2;
    localparam int TE  = 10;
    localparam int TEL = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [31:0] cmd_word = '0;
    logic        clr_ovf = 1'b0;
    logic        busy;
    logic [31:0] status;
    logic        lcd_on, lcd_en, lcd_rs, lcd_rw;
    logic [7:0]  lcd_data;

    always #5 clk = ~clk;

    lcd_ctrl #(
        .T_POWERUP   (TPU),
        .T_SETUP     (TS),
        .T_PULSE     (TP),
        .T_HOLD      (TH),
        .T_EXEC      (TE),
        .T_EXEC_LONG (TEL)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (rst_n),
        .i_cmd_valid (cmd_valid),
        .i_cmd_word  (cmd_word),
        .i_clr_ovf   (clr_ovf),
        .o_busy      (busy),
        .o_status    (status),
        .o_lcd_on    (lcd_on),
        .o_lcd_en    (lcd_en),
        .o_lcd_rs    (lcd_rs),
        .o_lcd_rw    (lcd_rw),
        .o_lcd_data  (lcd_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Cycle k is the interval after the k-th rising edge since reset release.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    typedef struct {
        logic       rs;
        logic [7:0] data;
        logic       rw;
        int         rise;
        int         width;
    } bus_t;

    bus_t obs_q[$];
    bus_t exp_q[$];

    initial begin
        bus_t cur;
        logic prev_en;
        prev_en = 1'b0;
        cur = '{1'b0, 8'h00, 1'b0, 0, 0};
        forever begin
            @(negedge clk);
            if (lcd_en === 1'b1 && !prev_en) cur = '{lcd_rs, lcd_data, lcd_rw, cyc, 0};
            if (lcd_en === 1'b1) cur.width++;
            if (lcd_en !== 1'b1 && prev_en) obs_q.push_back(cur);
            prev_en = (lcd_en === 1'b1);
        end
    end

    // Reference model: each bus write occupies a fixed window; a controller is free after m_last.
    int         m_last;
    logic       m_pend;
    logic       m_pend_rs;
    logic [7:0] m_pend_data;
    logic       m_ovf;
    logic       m_on;
    logic [7:0] init_seq [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    function automatic int write_len(input logic r, input logic [7:0] d);
        return TS + TP + TH + ((!r && d <= 8'h03) ? TEL : TE);
    endfunction

    task automatic m_start(input logic r, input logic [7:0] d, input int s);
        exp_q.push_back('{r, d, 1'b0, s + TS, TP});
        m_last = s + write_len(r, d) - 1;
    endtask

    task automatic m_advance(input int k);
        while (m_pend && m_last < k) begin
            m_pend = 1'b0;
            m_start(m_pend_rs, m_pend_data, m_last + 1);
        end
    endtask

    task automatic m_reset_init();
        int s;
        exp_q.delete();
        m_pend = 1'b0;
        m_ovf  = 1'b0;
        m_on   = 1'b0;
        s = TPU + 1;
        for (int i = 0; i < 6; i++) begin
            m_start(1'b0, init_seq[i], s);
            s = m_last + 2;
        end
    endtask

    task automatic m_strobe(input int c, input logic [31:0] w, input logic clr);
        m_advance(c + 1);
        if (c >= m_last && !m_pend) begin
            m_start(w[9], w[7:0], c + 1);
            m_on = w[31];
            if (clr) m_ovf = 1'b0;
        end else if (!m_pend) begin
            m_pend = 1'b1;
            m_pend_rs = w[9];
            m_pend_data = w[7:0];
            m_on = w[31];
            if (clr) m_ovf = 1'b0;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] w, input logic clr);
        cmd_valid = 1'b1;
        cmd_word  = w;
        clr_ovf   = clr;
        m_strobe(cyc, w, clr);
        tick();
        cmd_valid = 1'b0;
        clr_ovf   = 1'b0;
        cmd_word  = $urandom;
    endtask

    task automatic clear_ovf();
        clr_ovf = 1'b1;
        m_ovf = 1'b0;
        tick();
        clr_ovf = 1'b0;
    endtask

    task automatic expect_status(input string tag);
        logic [31:0] e;
        @(negedge clk);
        m_advance(cyc);
        e = '0;
        e[0]  = (cyc <= m_last);
        e[1]  = m_pend;
        e[2]  = m_ovf;
        e[3]  = 1'b1;
        e[31] = m_on;
        check(tag, status, e);
        check({tag, " busy"}, {31'b0, busy}, {31'b0, e[0]});
    endtask

    // Run until the model says the controller goes idle, check the busy edge, then the bus log.
    task automatic drain(input string tag);
        int guard;
        guard = 0;
        m_advance(cyc);
        while ((cyc < m_last || m_pend) && guard < 5000) begin
            tick();
            m_advance(cyc);
            guard++;
        end
        check({tag, " drain bound"}, guard < 5000, 1);
        if (cyc == m_last) begin
            @(negedge clk);
            check({tag, " busy last"}, {31'b0, busy}, 32'd1);
            tick();
        end
        @(negedge clk);
        check({tag, " idle busy"}, {31'b0, busy}, 32'd0);
        check({tag, " count"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            bus_t o, x;
            o = obs_q.pop_front();
            x = exp_q.pop_front();
            check({tag, " rs"},    {31'b0, o.rs}, {31'b0, x.rs});
            check({tag, " data"},  {24'b0, o.data}, {24'b0, x.data});
            check({tag, " rw"},    {31'b0, o.rw}, 32'd0);
            check({tag, " rise"},  o.rise, x.rise);
            check({tag, " width"}, o.width, x.width);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic [31:0] w;
        logic [7:0] d;

        repeat (3) @(posedge clk);
        #1;
        check("rst busy",   {31'b0, busy},   32'd0);
        check("rst status", status,          32'd0);
        check("rst en",     {31'b0, lcd_en}, 32'd0);
        check("rst rs",     {31'b0, lcd_rs}, 32'd0);
        check("rst rw",     {31'b0, lcd_rw}, 32'd0);
        check("rst data",   {24'b0, lcd_data}, 32'd0);
        check("rst on",     {31'b0, lcd_on}, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        m_reset_init();
        drain("init");
        expect_status("init status");

        c0 = cyc;
        strobe(32'h8000_0241, 1'b0);
        check("dir on",   {31'b0, lcd_on}, 32'd1);
        check("dir rs",   {31'b0, lcd_rs}, 32'd1);
        check("dir data", {24'b0, lcd_data}, 32'h41);
        check("dir end",  m_last, c0 + 18);
        drain("dir");

        strobe(32'h8000_0211, 1'b0);
        strobe(32'h8000_0222, 1'b0);
        strobe(32'h8000_0233, 1'b0);
        expect_status("ovf set");
        repeat (30) tick();
        expect_status("ovf sticky");
        clear_ovf();
        expect_status("ovf clr");
        drain("three");

        strobe(32'h0000_0001, 1'b0);
        drain("clear");
        strobe(32'h0000_0080, 1'b0);
        drain("ddram");

        strobe(32'h8000_0244, 1'b0);
        strobe(32'h8000_0245, 1'b0);
        while (cyc < m_last) tick();
        strobe(32'h8000_0246, 1'b0);
        expect_status("exec race");
        drain("race");

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 25)) tick();
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            w = {1'($urandom), 21'b0, 1'($urandom), 1'b0, d};
            strobe(w, $urandom_range(0, 7) == 0);
            expect_status("rand status");
        end
        drain("rand");
        clear_ovf();

        c0 = cyc;
        strobe(32'h8000_0250, 1'b0);
        strobe(32'h8000_0251, 1'b0);
        strobe(32'h8000_0252, 1'b0);
        while (cyc < c0 + TS + 2) tick();
        @(negedge clk);
        check("pulse en", {31'b0, lcd_en}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst mid en",     {31'b0, lcd_en}, 32'd0);
        check("rst mid status", status, 32'd0);
        @(negedge clk);
        @(negedge clk);
        obs_q.delete();
        rst_n = 1'b1;
        m_reset_init();
        drain("reinit");
        expect_status("reinit status");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
